param_adjust_ctrl: RTL and testbench

//   Sequences operator threshold edits for the NTSC colour-detection parameter bank.
//   - Turns debounced up/down buttons into step-write requests: press-once plus hold-to-auto-repeat.
//   - Each request carries the selected colour and field over a valid/ready write port.
//   - The parameter register bank applies each accepted request, so it no longer samples buttons directly.

---
 rtl/aug_param_pkg.sv | 46 ++++
 rtl/param_adjust_ctrl_if.sv | 22 ++
 rtl/tick_timer.sv | 37 +++
 rtl/param_adjust_ctrl.sv | 166 ++++++++++++++++
 tb/tb_param_adjust_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aug_param_pkg.sv
// Shared definitions for the colour-detection parameter bank: colour/field codes,
// parameter width and the step-sequencer FSM encoding.
package aug_param_pkg;

    localparam int PARAM_W = 10;

    typedef enum logic [1:0] {
        COLOR_GREEN  = 2'd0,
        COLOR_ORANGE = 2'd1,
        COLOR_PINK   = 2'd2,
        COLOR_BLUE   = 2'd3
    } color_e;

    // Codes 0 and 1 select no field at all.
    typedef enum logic [2:0] {
        FIELD_NONE0   = 3'd0,
        FIELD_NONE1   = 3'd1,
        FIELD_CB_MIN  = 3'd2,
        FIELD_CB_MAX  = 3'd3,
        FIELD_CR_MIN  = 3'd4,
        FIELD_CR_MAX  = 3'd5,
        FIELD_LUM_MIN = 3'd6,
        FIELD_LUM_MAX = 3'd7
    } field_e;

    localparam logic [2:0] FIELD_NONE_MAX = 3'd1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_HOLD     = 3'd2,
        ST_REPEAT   = 3'd3,
        ST_WAIT_REL = 3'd4
    } state_e;

    function automatic logic field_valid(input logic [2:0] f);
        return f > FIELD_NONE_MAX;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/param_adjust_ctrl_if.sv
// Step-write port from the button sequencer to the parameter register bank.
interface param_adjust_ctrl_if;
    import aug_param_pkg::*;

    logic               wr_valid;
    logic               wr_ready;
    logic [1:0]         wr_color;
    logic [2:0]         wr_field;
    logic               wr_dir;
    logic [PARAM_W-1:0] wr_step;

    modport master (
        output wr_valid, wr_color, wr_field, wr_dir, wr_step,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_color, wr_field, wr_dir, wr_step,
        output wr_ready
    );

endinterface

// File: rtl/tick_timer.sv
// Loadable down-counter; done_o pulses while enabled and the count has reached zero.
module tick_timer #(
    parameter int W = 25
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/param_adjust_ctrl.sv
// Turns debounced up/down buttons into step-write requests (tap plus hold-to-repeat).
// Define PARAM_ACCEL_EN to accelerate the repeat rate and double the step after FAST_AFTER repeats.
module param_adjust_ctrl
    import aug_param_pkg::*;
#(
    parameter int HOLD_DELAY = 20_000_000,
    parameter int REPEAT_PER = 2_000_000,
    parameter int FAST_PER   = 500_000,
    parameter int FAST_AFTER = 8,
    parameter int STEP       = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      button_up,
    input  logic                      button_down,
    input  logic [1:0]                sel_color,
    input  logic [2:0]                sel_field,
    param_adjust_ctrl_if.master       wr,
    output logic                      repeating
);

    localparam int TMR_W = $clog2(max3(HOLD_DELAY, REPEAT_PER, FAST_PER) + 1);

    if (HOLD_DELAY < 1 || REPEAT_PER < 1 || FAST_PER < 1 || FAST_AFTER < 0 ||
        STEP < 1 || 2 * STEP >= (1 << PARAM_W)) begin : g_cfg_check
        $error("param_adjust_ctrl: invalid timing or step parameters");
    end

    state_e           state_q, state_d;
    logic [1:0]       color_q, color_d;
    logic [2:0]       field_q, field_d;
    logic             dir_q, dir_d;
    logic             first_q, first_d;

    logic             press, dir_in, both_high, moved;
    logic             tmr_load, tmr_clr, tmr_en, tmr_done;
    logic [TMR_W-1:0] tmr_val, hold_val, rep_val;

    // Buttons are active-low; exactly one low is a press, up low means add.
    assign press     = button_up ^ button_down;
    assign dir_in    = ~button_up;
    assign both_high = button_up & button_down;
    assign moved     = !press || (dir_in != dir_q) ||
                       (sel_color != color_q) || (sel_field != field_q);
    assign hold_val  = TMR_W'(HOLD_DELAY - 1);

`ifdef PARAM_ACCEL_EN
    localparam int RCNT_W = (FAST_AFTER < 1) ? 1 : $clog2(FAST_AFTER + 1);

    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic              fast;

    assign fast       = (rcnt_q == RCNT_W'(FAST_AFTER));
    assign rep_val    = fast ? TMR_W'(FAST_PER - 1) : TMR_W'(REPEAT_PER - 1);
    assign wr.wr_step = fast ? PARAM_W'(2 * STEP) : PARAM_W'(STEP);

    // Saturating count of completed slow/fast repeat periods in this press.
    always_comb begin
        rcnt_d = rcnt_q;
        if (state_d == ST_IDLE) begin
            rcnt_d = '0;
        end else if ((state_q == ST_REPEAT) && (state_d == ST_ISSUE) && !fast) begin
            rcnt_d = rcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rcnt_q <= '0;
        end else begin
            rcnt_q <= rcnt_d;
        end
    end
`else
    assign rep_val    = TMR_W'(REPEAT_PER - 1);
    assign wr.wr_step = PARAM_W'(STEP);
`endif

    always_comb begin
        state_d  = state_q;
        color_d  = color_q;
        field_d  = field_q;
        dir_d    = dir_q;
        first_d  = first_q;
        tmr_load = 1'b0;
        tmr_val  = hold_val;
        unique case (state_q)
            ST_IDLE: begin
                if (press) begin
                    if (field_valid(sel_field)) begin
                        state_d = ST_ISSUE;
                        color_d = sel_color;
                        field_d = sel_field;
                        dir_d   = dir_in;
                        first_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT_REL;
                    end
                end
            end
            ST_ISSUE: begin
                if (wr.wr_ready) begin
                    tmr_load = 1'b1;
                    tmr_val  = first_q ? hold_val : rep_val;
                    first_d  = 1'b0;
                    state_d  = first_q ? ST_HOLD : ST_REPEAT;
                end
                // A handshake on this edge still completes; only the follow-up is cancelled.
                if (moved) begin
                    state_d = ST_WAIT_REL;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (moved) begin
                    state_d = ST_WAIT_REL;
                end else if (tmr_done) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT_REL: begin
                if (both_high) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            color_q <= '0;
            field_q <= '0;
            dir_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            color_q <= color_d;
            field_q <= field_d;
            dir_q   <= dir_d;
            first_q <= first_d;
        end
    end

    assign tmr_clr = (state_d == ST_IDLE);
    assign tmr_en  = (state_q == ST_HOLD) || (state_q == ST_REPEAT);

    tick_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk        (clock),
        .rst        (reset),
        .clr_i      (tmr_clr),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .done_o     (tmr_done)
    );

    assign wr.wr_valid = (state_q == ST_ISSUE);
    assign wr.wr_color = color_q;
    assign wr.wr_field = field_q;
    assign wr.wr_dir   = dir_q;
    assign repeating   = (state_q == ST_REPEAT);

endmodule

// File: tb/tb_param_adjust_ctrl.sv
// Bench for param_adjust_ctrl: directed scenarios plus random button/ready activity
// against a cycle-level behavioural model of the step sequencer.
module tb_param_adjust_ctrl;

    localparam int HOLD_DELAY = 20;
    localparam int REPEAT_PER = 5;
    localparam int FAST_PER   = 2;
    localparam int FAST_AFTER = 3;
    localparam int STEP       = 8;
`ifdef PARAM_ACCEL_EN
    localparam bit ACCEL = 1'b1;
`else
    localparam bit ACCEL = 1'b0;
`endif

    logic       clock       = 1'b0;
    logic       reset       = 1'b1;
    logic       button_up   = 1'b1;
    logic       button_down = 1'b1;
    logic [1:0] sel_color   = 2'd0;
    logic [2:0] sel_field   = 3'd0;
    logic       repeating;

    param_adjust_ctrl_if wr ();

    param_adjust_ctrl #(
        .HOLD_DELAY (HOLD_DELAY),
        .REPEAT_PER (REPEAT_PER),
        .FAST_PER   (FAST_PER),
        .FAST_AFTER (FAST_AFTER),
        .STEP       (STEP)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .button_up   (button_up),
        .button_down (button_down),
        .sel_color   (sel_color),
        .sel_field   (sel_field),
        .wr          (wr),
        .repeating   (repeating)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        logic [1:0] col;
        logic [2:0] fld;
        logic       dir;
        logic [9:0] step;
    } hs_t;
    hs_t hs_q[$];

    // Model: a press session either has a request pending or is counting down the gap
    // (hold delay after the first accept, repeat period afterwards) to the next one.
    bit         m_busy, m_wait, m_pend, m_first, m_inrep;
    int         m_gap, m_nrep;
    logic [1:0] m_col;
    logic [2:0] m_fld;
    logic       m_dir;

    always @(posedge clock) begin : model_b
        bit pressed;
        bit d;
        pressed = (button_up != button_down);
        d       = !button_up;
        if (reset) begin
            m_busy = 0; m_wait = 0; m_pend = 0; m_first = 0; m_inrep = 0;
            m_gap = 0; m_nrep = 0; m_col = 2'd0; m_fld = 3'd0; m_dir = 1'b0;
        end else if (m_busy) begin
            if (!pressed || d != m_dir || sel_color != m_col || sel_field != m_fld) begin
                m_busy = 0; m_wait = 1; m_pend = 0;
            end else if (m_pend) begin
                if (wr.wr_ready) begin
                    m_pend  = 0;
                    m_inrep = !m_first;
                    if (m_first) m_gap = HOLD_DELAY;
                    else m_gap = (ACCEL && m_nrep >= FAST_AFTER) ? FAST_PER : REPEAT_PER;
                    m_first = 0;
                end
            end else begin
                m_gap = m_gap - 1;
                if (m_gap == 0) begin
                    m_pend = 1;
                    if (m_inrep && m_nrep < FAST_AFTER) m_nrep = m_nrep + 1;
                end
            end
        end else if (m_wait) begin
            if (button_up && button_down) begin
                m_wait = 0; m_nrep = 0;
            end
        end else if (pressed) begin
            if (sel_field >= 3'd2) begin
                m_busy = 1; m_pend = 1; m_first = 1; m_inrep = 0;
                m_col = sel_color; m_fld = sel_field; m_dir = d;
            end else begin
                m_wait = 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic compare();
        int exp_step;
        exp_step = (ACCEL && m_nrep >= FAST_AFTER) ? 2 * STEP : STEP;
        chk("wr_valid", 32'(wr.wr_valid), 32'(m_pend));
        chk("wr_color", 32'(wr.wr_color), 32'(m_col));
        chk("wr_field", 32'(wr.wr_field), 32'(m_fld));
        chk("wr_dir", 32'(wr.wr_dir), 32'(m_dir));
        chk("wr_step", 32'(wr.wr_step), 32'(exp_step));
        chk("repeating", 32'(repeating), 32'(m_busy && !m_pend && m_inrep));
    endtask

    // One clock: compare and log handshakes on the falling edge, return just after the rising edge.
    task automatic tick();
        hs_t h;
        @(negedge clock);
        cyc++;
        compare();
        if (wr.wr_valid === 1'b1 && wr.wr_ready === 1'b1) begin
            h.cyc = cyc; h.col = wr.wr_color; h.fld = wr.wr_field;
            h.dir = wr.wr_dir; h.step = wr.wr_step;
            hs_q.push_back(h);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        int base;
        int c0;
        wr.wr_ready = 1'b0;
        @(posedge clock);
        #1;
        repeat (3) tick();
        chk("rst_valid", 32'(wr.wr_valid), 32'd0);
        chk("rst_step", 32'(wr.wr_step), 32'(STEP));
        chk("rst_field", 32'(wr.wr_field), 32'd0);
        chk("rst_repeating", 32'(repeating), 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        // Tap up: one request, then nothing after release.
        sel_color = 2'd1; sel_field = 3'd5; wr.wr_ready = 1'b1;
        base = hs_q.size();
        button_up = 1'b0;
        tick();
        button_up = 1'b1;
        repeat (30) tick();
        chk("tap_count", 32'(hs_q.size() - base), 32'd1);
        if (hs_q.size() > base) begin
            chk("tap_color", 32'(hs_q[base].col), 32'd1);
            chk("tap_field", 32'(hs_q[base].fld), 32'd5);
            chk("tap_dir", 32'(hs_q[base].dir), 32'd1);
            chk("tap_step", 32'(hs_q[base].step), 32'd8);
        end

        // Hold down: first at press+1, then HOLD_DELAY+1, then REPEAT_PER+1 spacing.
        sel_color = 2'd3; sel_field = 3'd2;
        base = hs_q.size();
        c0 = cyc;
        button_down = 1'b0;
        repeat (60) tick();
        button_down = 1'b1;
        repeat (10) tick();
        chk("hold_count", 32'(hs_q.size() - base), ACCEL ? 32'd11 : 32'd8);
        if (hs_q.size() >= base + 6) begin
            chk("hold_first", 32'(hs_q[base].cyc), 32'(c0 + 2));
            chk("hold_gap1", 32'(hs_q[base+1].cyc - hs_q[base].cyc), 32'd21);
            chk("hold_gap2", 32'(hs_q[base+2].cyc - hs_q[base+1].cyc), 32'd6);
            chk("hold_gap3", 32'(hs_q[base+3].cyc - hs_q[base+2].cyc), 32'd6);
            chk("hold_gap5", 32'(hs_q[base+5].cyc - hs_q[base+4].cyc), ACCEL ? 32'd3 : 32'd6);
            chk("hold_step3", 32'(hs_q[base+3].step), 32'd8);
            chk("hold_step4", 32'(hs_q[base+4].step), ACCEL ? 32'd16 : 32'd8);
            for (int i = base; i < hs_q.size(); i++) chk("hold_dir", 32'(hs_q[i].dir), 32'd0);
        end

        // Stall: request held while not ready, exactly one once ready rises.
        sel_color = 2'd0; sel_field = 3'd7; wr.wr_ready = 1'b0;
        base = hs_q.size();
        button_up = 1'b0;
        repeat (10) tick();
        chk("stall_valid", 32'(wr.wr_valid), 32'd1);
        chk("stall_field", 32'(wr.wr_field), 32'd7);
        wr.wr_ready = 1'b1;
        tick();
        button_up = 1'b1;
        repeat (10) tick();
        chk("stall_count", 32'(hs_q.size() - base), 32'd1);

        // Field change while pending drops the request; no field-6 request until re-press.
        wr.wr_ready = 1'b0; sel_field = 3'd7;
        button_up = 1'b0;
        repeat (3) tick();
        sel_field = 3'd6;
        tick();
        chk("abort_valid", 32'(wr.wr_valid), 32'd0);
        wr.wr_ready = 1'b1;
        base = hs_q.size();
        repeat (30) tick();
        chk("abort_none", 32'(hs_q.size() - base), 32'd0);
        button_up = 1'b1;
        repeat (2) tick();
        button_up = 1'b0;
        repeat (3) tick();
        button_up = 1'b1;
        repeat (5) tick();
        chk("repress_count", 32'(hs_q.size() - base), 32'd1);
        if (hs_q.size() > base) chk("repress_field", 32'(hs_q[base].fld), 32'd6);

        // Both low, then a press on field 0 that later moves to a real field.
        sel_field = 3'd5;
        base = hs_q.size();
        button_up = 1'b0; button_down = 1'b0;
        repeat (20) tick();
        button_up = 1'b1; button_down = 1'b1;
        tick();
        sel_field = 3'd0;
        button_up = 1'b0;
        repeat (3) tick();
        sel_field = 3'd5;
        repeat (20) tick();
        chk("noreq_count", 32'(hs_q.size() - base), 32'd0);
        button_up = 1'b1;
        repeat (2) tick();

        // Reset in the middle of a hold.
        sel_field = 3'd4; button_up = 1'b0;
        repeat (30) tick();
        reset = 1'b1;
        tick();
        chk("midrst_valid", 32'(wr.wr_valid), 32'd0);
        chk("midrst_repeating", 32'(repeating), 32'd0);
        reset = 1'b0;
        tick();
        chk("postrst_reissue", 32'(wr.wr_valid), 32'd1);
        button_up = 1'b1;
        repeat (3) tick();

        // Random activity against the model.
        for (int n = 0; n < 150; n++) begin
            int dur;
            int kind;
            dur  = int'($urandom_range(1, 45));
            kind = int'($urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0) sel_color = 2'($urandom);
            if ($urandom_range(0, 3) == 0) sel_field = 3'($urandom);
            if (kind <= 5) begin
                if ($urandom_range(0, 1) == 0) begin button_up = 1'b0; button_down = 1'b1; end
                else begin button_up = 1'b1; button_down = 1'b0; end
            end else if (kind == 6) begin
                button_up = 1'b0; button_down = 1'b0;
            end else begin
                button_up = 1'b1; button_down = 1'b1;
            end
            for (int j = 0; j < dur; j++) begin
                wr.wr_ready = ($urandom_range(0, 3) != 0);
                reset = ($urandom_range(0, 199) == 0);
                if ($urandom_range(0, 79) == 0) sel_field = 3'($urandom);
                tick();
            end
        end
        reset = 1'b0;
        button_up = 1'b1; button_down = 1'b1;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
